// File: rtl/demux2_buf.sv
// rtl/demux2_buf.sv - 1-to-2 routing demultiplexer with a one-entry holding buffer per output port
// Each port has a valid/ready handshake of its own, plus a counter of delivered words.
module demux2_buf #(
  parameter int W = 8,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  input  logic         s,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y0,
  output logic         y0_valid,
  input  logic         y0_ready,
  output logic [W-1:0] y1,
  output logic         y1_valid,
  input  logic         y1_ready,
  output logic [C-1:0] cnt0,
  output logic [C-1:0] cnt1
);

  logic take0, take1;
  logic room0, room1;
  logic load0, load1;

  // A full buffer still has room when its word leaves in the same cycle.
  assign take0 = y0_valid && y0_ready;
  assign take1 = y1_valid && y1_ready;
  assign room0 = !y0_valid || y0_ready;
  assign room1 = !y1_valid || y1_ready;

  assign in_ready = !reset && (s ? room1 : room0);
  assign load0    = in_valid && in_ready && !s;
  assign load1    = in_valid && in_ready && s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y0       <= '0;
      y0_valid <= 1'b0;
      cnt0     <= '0;
    end else begin
      if (load0) begin
        y0       <= d;
        y0_valid <= 1'b1;
      end else if (take0) begin
        y0_valid <= 1'b0;
      end
      if (take0) cnt0 <= cnt0 + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y1       <= '0;
      y1_valid <= 1'b0;
      cnt1     <= '0;
    end else begin
      if (load1) begin
        y1       <= d;
        y1_valid <= 1'b1;
      end else if (take1) begin
        y1_valid <= 1'b0;
      end
      if (take1) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: doc/demux2_buf.md
DEMUX2_BUF -- requirements
Module: demux2_buf

Interface
REQ-001 Parameter W, default 8: data width in bits of d, y0 and y1.
REQ-002 Parameter C, default 8: width in bits of each transfer counter.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 d  input  W  input data word.
REQ-007 s  input  1  destination select: 0 routes to port 0, 1 routes to port 1.
REQ-008 in_valid  input  1  d and s are presented for transfer.
REQ-009 in_ready  output  1  block can accept the input word this cycle.
REQ-010 y0  output  W  port-0 data, from the port-0 holding register.
REQ-011 y0_valid  output  1  y0 holds an undelivered word.
REQ-012 y0_ready  input  1  port-0 consumer accepts y0.
REQ-013 y1  output  W  port-1 data, from the port-1 holding register.
REQ-014 y1_valid  output  1  y1 holds an undelivered word.
REQ-015 y1_ready  input  1  port-1 consumer accepts y1.
REQ-016 cnt0  output  C  number of completed port-0 output handshakes, modulo 2^C.
REQ-017 cnt1  output  C  number of completed port-1 output handshakes, modulo 2^C.

Function
REQ-018 Structure: one W-bit holding register and one valid flag per output port (one-entry buffer each); yk and yk_valid are driven directly from port k's register and flag.
REQ-019 Definitions:
- Input handshake: in_valid && in_ready at a rising clock edge.
- Output handshake on port k: yk_valid && yk_ready at a rising clock edge.
REQ-020 in_ready is combinational from s and port-s state.
- Equals 1 when buffer s is empty, or when buffer s is valid and ys_ready = 1 in the same cycle.
- Otherwise equals 0.
- Does not depend on in_valid.
REQ-021 Input handshake loads d into buffer s and sets ys_valid; the word appears on ys one cycle after acceptance (latency 1).
REQ-022 s and d are sampled only in the input-handshake cycle; s and d changes while in_valid = 0 or in_ready = 0 have no effect.
REQ-023 The non-selected buffer is never modified by an input handshake.
REQ-024 Output handshake on port k with no same-cycle reload of port k: yk_valid clears on the next edge.
REQ-025 Output handshake on port k with a same-cycle input handshake targeting port k: yk_valid stays 1 and yk takes the new word (back-to-back throughput of one word per cycle per port).
REQ-026 While yk_valid = 1 and yk_ready = 0, yk and yk_valid hold stable; no word is ever overwritten or dropped.
REQ-027 Port-0 and port-1 output handshakes in the same cycle are independent, and both complete.
REQ-028 cntk increments by 1 on each port-k output handshake and wraps from 2^C-1 to 0; it is unaffected by input handshakes.
REQ-029 A stall on one port does not block input words destined for the other port.

Reset
REQ-030 While reset = 1, regardless of clk:
- y0_valid = y1_valid = 0
- y0 = y1 = 0
- cnt0 = cnt1 = 0
- in_ready = 0
REQ-031 Reset asserted mid-operation discards any buffered words without delivery; the first cycle after reset deasserts has in_ready = 1 for either value of s.

Verification
REQ-032 Reset release, then d=8'hA5, s=0, in_valid=1 for one cycle with y0_ready=0 -> next cycle y0=8'hA5, y0_valid=1, y1_valid=0; y0 holds until y0_ready=1, then y0_valid=0 and cnt0=1.
REQ-033 y0 buffer full with y0_ready=0; present s=0, in_valid=1 -> in_ready=0 and y0 unchanged; present s=1, d=8'h3C in the same stall -> accepted, y1=8'h3C next cycle.
REQ-034 Continuous stream 8'h01..8'h10 to s=1 with y1_ready=1 -> in_ready stays 1, one word per cycle on y1 in order, cnt1=16.
REQ-035 Both ports valid, y0_ready=y1_ready=1 in the same cycle -> both valid flags clear, cnt0 and cnt1 each increment by 1.
REQ-036 Perform 257 port-0 handshakes from reset with C=8 -> cnt0 reads 1 (wrap past 255 to 0).
REQ-037 Assert reset asynchronously (between clock edges) while y1_valid=1 -> y1_valid, y1 and cnt1 go to 0 immediately; after release, in_ready=1.
